cpu_pio_debounced_irq: RTL and testbench
========================================

// Module: cpu_pio_debounced_irq
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons/switches: per-bit 2-flop sync,
//  counter debounce, sticky edge capture, maskable level IRQ. Sits on the CPU data
//  bus beside other PIOs; register map compatible with standard PIO (data/mask/edge).
// PARAMETERS
//  WIDTH            4       number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000   consecutive stable cycles before a change is accepted (>=1)
//  EDGE_TYPE        0       0=falling, 1=rising, 2=any edge sets edgecapture
//  INIT_VALUE       4'hF    reset value of sync and debounced regs (active-low buttons idle high)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous reset, active-low
//  chipselect  in   1      slave select
//  address     in   2      word address
//  write_n     in   1      active-low write strobe (valid with chipselect)
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous inputs
//  readdata    out  32     registered read data, zero-extended
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Reset: sync/stable = INIT_VALUE; counters, irqmask, edgecapture, readdata = 0; irq = 0.
//  Sync: 2 flops per bit, no reset-release glitch (both load INIT_VALUE).
//  Debounce per bit: cnt cleared when sync==stable; else if cnt==DEBOUNCE_CYCLES-1
//   then stable<=sync, cnt<=0, else cnt++. Counter width $clog2(DEBOUNCE_CYCLES+1).
//   A bounce (sync returns to stable) before terminal count restarts the count.
//  Latency in_port change -> stable: 2 + DEBOUNCE_CYCLES cycles; -> readdata: +1.
//  Edge: edge[i] = stable transition per EDGE_TYPE in the cycle stable updates.
//  Register map (word addr):
//   0 data        RO  stable[WIDTH-1:0]; writes ignored
//   1 reserved    RO  reads 0; writes ignored
//   2 irqmask     RW  writedata[WIDTH-1:0]
//   3 edgecapture R/W1C  sticky edge bits; write 1 clears bit
//  Write strobe = chipselect & ~write_n; takes effect next cycle.
//  Same-cycle edge set and W1C on a bit: set wins (bit stays 1).
//  readdata registered every cycle from address mux (read latency 1, no read strobe);
//   upper 32-WIDTH bits always 0; reads have no side effects.
//  irq = |(edgecapture & irqmask), derived from registers only (glitch-free).
//   Unmasking an already captured edge raises irq the next cycle.
//  Reset mid-debounce: count discarded, stable returns to INIT_VALUE, no edge recorded.
// STRUCTURE
//  Shared package cpu_pio_pkg: register address constants (ADDR_DATA=0, ADDR_MASK=2,
//   ADDR_EDGE=3), EDGE_FALL/EDGE_RISE/EDGE_ANY encodings.
//  Sub-module pio_debounce_bit (sync + counter + stable + edge output, params
//   DEBOUNCE_CYCLES, EDGE_TYPE, INIT); WIDTH instances via generate. Top holds
//   irqmask, edgecapture, readdata mux, irq.
// TESTING (bench: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, INIT_VALUE=4'hF)
//  1 Reset, idle in_port=4'hF -> readdata 0 at reset then data reads 4'hF; irq=0.
//  2 in_port[0] 1->0 held -> data bit0=0 after 2+4 cycles, edgecapture=4'h1, irq=0 (mask 0).
//  3 Write mask=4'h1 with edge pending -> irq=1 next cycle; write 4'h1 to addr 3 -> irq=0.
//  4 in_port[1] pulses low 3 cycles then high -> no data change, edgecapture stays 0.
//  5 Edge on bit2 in same cycle as W1C of 4'h4 -> edgecapture bit2 remains 1.
//  6 Assert reset_n=0 during a debounce count -> all regs reset values, no edge after release.

Source files
------------

// File: rtl/cpu_pio_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pio_pkg
//   Shared definitions for the CPU-side PIO blocks.
//   - Word addresses of the standard PIO register map.
//   - Encodings of the edge-capture sensitivity.
//   - edge_hit(): decides whether an old->new transition counts as an edge
//     for a given sensitivity.
// ---------------------------------------------------------------------------
package cpu_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_hit(input int edge_type, input logic old_val,
                                      input logic new_val);
        logic hit;
        case (edge_type)
            EDGE_FALL: hit = old_val & ~new_val;
            EDGE_RISE: hit = ~old_val & new_val;
            default:   hit = old_val ^ new_val;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// ---------------------------------------------------------------------------
// pio_debounce_bit
//   One input bit: 2-flop synchroniser, counter debounce and edge detector.
//   A change on the synchronised input is accepted into 'stable' only after
//   it has been seen for DEBOUNCE_CYCLES consecutive cycles; any return to the
//   current stable value restarts the count.
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active-low
//   raw        in   raw asynchronous input
//   stable     out  debounced value (INIT after reset)
//   edge_pulse out  one-cycle pulse in the cycle 'stable' is about to change,
//                   qualified by EDGE_TYPE
// ---------------------------------------------------------------------------
module pio_debounce_bit
    import cpu_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = EDGE_FALL,
    parameter logic INIT            = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic edge_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept     = (sync_q2 != stable) && (cnt == CNT_LAST);
    assign edge_pulse = accept && edge_hit(EDGE_TYPE, stable, sync_q2);

    // Both synchroniser flops reset to INIT so releasing reset with the input
    // idle never looks like a transition to the debounce counter.
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= INIT;
            sync_q2 <= INIT;
            stable  <= INIT;
            cnt     <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_pio_debounced_irq.sv
// ---------------------------------------------------------------------------
// cpu_pio_debounced_irq
//   Avalon-MM input PIO with per-bit debounce, sticky edge capture and a
//   maskable level interrupt. Register map (word address):
//     0 data        RO    debounced inputs
//     1 reserved    RO    reads 0
//     2 irqmask     RW
//     3 edgecapture R/W1C sticky edge bits; a new edge beats a same-cycle clear
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   chipselect, address   slave select and word address
//   write_n, writedata    active-low write strobe and write data
//   in_port [WIDTH]       raw asynchronous inputs
//   readdata [32]         registered read data (latency 1), zero-extended
//   irq                   level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module cpu_pio_debounced_irq
    import cpu_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      read_next;
    logic             wr_en;

    // Only the low WIDTH bits of writedata are meaningful.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE      (EDGE_TYPE),
            .INIT           (INIT_VALUE[i])
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (in_port[i]),
            .stable    (stable[i]),
            .edge_pulse(edge_bits[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w1c = '0;
        if (wr_en && (address == ADDR_EDGE)) begin
            w1c = writedata[WIDTH-1:0];
        end
        // Clear first, then OR in new edges: a same-cycle edge wins.
        edge_next = (edgecapture & ~w1c) | edge_bits;
    end

    always_comb begin
        read_next = '0;
        case (address)
            ADDR_DATA: read_next[WIDTH-1:0] = stable;
            ADDR_MASK: read_next[WIDTH-1:0] = irqmask;
            ADDR_EDGE: read_next[WIDTH-1:0] = edgecapture;
            default:   read_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            if (wr_en && (address == ADDR_MASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= edge_next;
            readdata    <= read_next;
        end
    end

    // Built from flops only, so it cannot glitch on bus or input activity.
    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_cpu_pio_debounced_irq.sv
// ---------------------------------------------------------------------------
// tb_cpu_pio_debounced_irq
//   Directed scenarios followed by random bus traffic and random input
//   bouncing. A reference model predicts each read result and the irq level;
//   predictions go into queues and a separate monitor compares them with the
//   DUT on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cpu_pio_debounced_irq;

    localparam int         WIDTH = 4;
    localparam int         DC    = 4;
    localparam logic [3:0] INIT  = 4'hF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = INIT;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_pio_debounced_irq #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (0),
        .INIT_VALUE     (INIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .address   (address),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input reaches the debouncer two clocks late; the debounced value adopts
    // a new level once the last DC synchronised samples all agree on it.
    logic [3:0] m_s1 = INIT, m_s2 = INIT, m_stable = INIT;
    logic [3:0] m_mask = '0, m_edge = '0;
    logic [3:0] hist[$];
    logic [31:0] rd_q[$];
    logic        irq_q[$];

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_stable};
            2'd2:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_edge};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = INIT; m_s2 = INIT; m_stable = INIT;
        m_mask = '0; m_edge = '0;
        hist.delete(); rd_q.delete(); irq_q.delete();
    endtask

    task automatic model_step();
        logic [3:0] new_stable, falls, clr;
        logic       uniform;
        hist.push_back(m_s2);
        if (hist.size() > DC) void'(hist.pop_front());
        new_stable = m_stable;
        for (int i = 0; i < WIDTH; i++) begin
            if (hist.size() == DC) begin
                uniform = 1'b1;
                foreach (hist[k]) if (hist[k][i] != hist[0][i]) uniform = 1'b0;
                if (uniform) new_stable[i] = hist[0][i];
            end
        end
        falls = m_stable & ~new_stable;
        if (chipselect && write_n) rd_q.push_back(model_read(address));
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'd0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        m_edge   = (m_edge & ~clr) | falls;
        m_stable = new_stable;
        m_s2     = m_s1;
        m_s1     = in_port;
        irq_q.push_back(|(m_edge & m_mask));
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_q.size() > 0) check("sb_readdata", readdata, rd_q.pop_front());
            if (irq_q.size() > 0) check("sb_irq", {31'd0, irq}, {31'd0, irq_q.pop_front()});
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick();
        chipselect = 1'b0;
        @(negedge clk);
        check(name, readdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0] flips;

        // 1: reset state, then idle inputs read back as 4'hF
        repeat (2) @(negedge clk);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) tick();
        read_check(2'd0, 32'h0000_000F, "idle_data");
        check("idle_irq", {31'd0, irq}, 32'd0);

        // 2: bit0 falls and is held; accepted after 2+DC cycles
        in_port = 4'hE;
        repeat (2 + DC) tick();
        read_check(2'd0, 32'h0000_000E, "fall_data");
        read_check(2'd3, 32'h0000_0001, "fall_edge");
        check("fall_irq_masked", {31'd0, irq}, 32'd0);

        // 3: unmasking a captured edge raises irq; W1C drops it
        bus_write(2'd2, 32'h0000_0001);
        @(negedge clk);
        check("unmask_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h0000_0001);
        @(negedge clk);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // 4: bit1 glitch shorter than the debounce window is rejected
        in_port = 4'hC;
        repeat (DC - 1) tick();
        in_port = 4'hE;
        repeat (2 * DC) tick();
        read_check(2'd0, 32'h0000_000E, "bounce_data");
        read_check(2'd3, 32'h0000_0000, "bounce_edge");

        // 5: bit2 edge lands in the same cycle as its W1C; the edge wins
        in_port = 4'hA;
        repeat (1 + DC) tick();
        bus_write(2'd3, 32'h0000_0004);
        read_check(2'd3, 32'h0000_0004, "set_beats_clear");

        // 6: reset in the middle of a debounce count
        bus_write(2'd3, 32'h0000_000F);
        in_port = 4'h2;
        repeat (3) tick();
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        in_port = INIT;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2 * DC + 2) tick();
        read_check(2'd0, 32'h0000_000F, "post_reset_data");
        read_check(2'd3, 32'h0000_0000, "post_reset_edge");
        read_check(2'd2, 32'h0000_0000, "post_reset_mask");

        // Random traffic: bouncing inputs and mixed bus operations
        for (int cyc = 0; cyc < 2000; cyc++) begin
            flips = '0;
            for (int i = 0; i < WIDTH; i++) flips[i] = ($urandom_range(0, 7) == 0);
            in_port   = in_port ^ flips;
            r         = int'($urandom_range(0, 10));
            writedata = $urandom;
            address   = 2'($urandom_range(0, 3));
            if (r <= 5) begin
                chipselect = 1'b1; write_n = 1'b1;
            end else if (r <= 7) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'd2;
            end else if (r == 8) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'd3;
            end else if (r == 9) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'($urandom_range(0, 1));
            end else begin
                chipselect = 1'b0; write_n = 1'($urandom_range(0, 1));
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("scoreboard_drained", rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
